mem_responder: RTL and testbench

//  Bus-side responder that services the read/write strobes issued by the

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 31 +++
 rtl/resp_mem_array.sv | 37 +++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the instruction controller, the memory responder and their benches.
package ctrl_pkg;

    localparam int CTRL_DW = 32;
    localparam int CTRL_AW = 4;

    // Responder FSM: IDLE accepts, BUSY counts wait states, RESP drives the one-cycle pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // One controller instruction as it travels towards the responder.
    typedef struct packed {
        op_t                  op;
        logic [CTRL_AW-1:0]   addr;
        logic [CTRL_DW-1:0]   data;
    } instr_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the instruction controller and the memory responder.
//
// Handshake: the controller raises exactly one of read/write (with addr/wdata) and the
// responder accepts it on the first posedge where ready=1. ready stays low from the
// accepting edge until the response cycle has ended; strobes seen while ready=0 are
// ignored. Completion is a one-cycle rvalid (read, rdata valid with it) or wack (write)
// pulse. read and write high together while ready=1 is rejected with a one-cycle error.
interface mem_responder_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wack;
    logic          error;

    modport master (
        output read, write, addr, wdata,
        input  ready, rdata, rvalid, wack, error
    );

    modport slave (
        input  read, write, addr, wdata,
        output ready, rdata, rvalid, wack, error
    );
endinterface

// File: rtl/resp_mem_array.sv
// 2**AW x DW register-file storage: async clear, synchronous write, registered read port.
module resp_mem_array #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage words: cleared on reset, written when the responder performs a write.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: loads only on a read access, otherwise holds the last read word.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write at a time, inserts WAIT_CYCLES wait states,
// then performs the access and pulses rvalid or wack for one cycle.
module mem_responder
    import ctrl_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetN,
    mem_responder_if.slave bus,
    output resp_state_t state_dbg
);
    resp_state_t   state;
    op_t           op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    cnt;
    logic          rvalid_q;
    logic          wack_q;
    logic          error_q;
    logic          access;
    logic          mem_we;
    logic          mem_re;

    // The access happens on the edge that leaves BUSY with the wait counter exhausted.
    assign access = (state == BUSY) && (cnt == 4'd0);
    assign mem_we = access && (op_q == OP_WRITE);
    assign mem_re = access && (op_q == OP_READ);

    // Request FSM, wait counter and the one-cycle completion/error pulses.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= 4'd0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            error_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.read ^ bus.write) begin
                        op_q    <= bus.write ? OP_WRITE : OP_READ;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= BUSY;
                    end else if (bus.read && bus.write) begin
                        error_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        if (op_q == OP_READ) begin
                            rvalid_q <= 1'b1;
                        end else begin
                            wack_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    resp_mem_array #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clock  (clock),
        .resetN (resetN),
        .we     (mem_we),
        .re     (mem_re),
        .addr   (addr_q),
        .wdata  (wdata_q),
        .rdata  (bus.rdata)
    );

    assign bus.ready  = (state == IDLE);
    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;
    assign bus.error  = error_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance see identical
// stimulus; the reference model predicts each response into per-instance queues.
module tb_mem_responder;
    import ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    mem_responder_if #(.DW(DW), .AW(AW)) bus2 ();
    mem_responder_if #(.DW(DW), .AW(AW)) bus0 ();
    resp_state_t st2;
    resp_state_t st0;

    mem_responder #(.DW(DW), .AW(AW), .WAIT_CYCLES(2)) dut2 (
        .clock     (clock),
        .resetN    (resetN),
        .bus       (bus2),
        .state_dbg (st2)
    );

    mem_responder #(.DW(DW), .AW(AW), .WAIT_CYCLES(0)) dut0 (
        .clock     (clock),
        .resetN    (resetN),
        .bus       (bus0),
        .state_dbg (st0)
    );

    // ---------------- model and scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] model_mem [16];
    logic [33:0]   exp_q2[$];
    logic [33:0]   exp_q0[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
    endtask

    task automatic push_both(input logic [33:0] e);
        exp_q2.push_back(e);
        exp_q0.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus2.read = rd;  bus0.read = rd;
        bus2.write = wr; bus0.write = wr;
        bus2.addr = a;   bus0.addr = a;
        bus2.wdata = d;  bus0.wdata = d;
    endtask

    // Wait (at negedges) until both instances are idle; bounded.
    task automatic wait_idle();
        int waited = 0;
        while (!(bus2.ready && bus0.ready) && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        if (!(bus2.ready && bus0.ready)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready2=%b ready0=%b, required 1", bus2.ready, bus0.ready);
        end
    endtask

    // One-cycle request; returns at the negedge after the accepting posedge.
    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        drive(rd, wr, a, d);
        if (rd && wr) begin
            push_both({K_ERR, 32'h0});
        end else if (rd) begin
            push_both({K_RD, model_mem[a]});
        end else if (wr) begin
            push_both({K_WR, 32'h0});
            model_mem[a] = d;
        end
        @(negedge clock);
        drive(1'b0, 1'b0, AW'($urandom_range(0, 15)), $urandom);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clock) begin
        logic [1:0]  kind;
        logic [33:0] act;
        logic [33:0] e;
        int          np;
        if (resetN) begin
            np = int'(bus2.rvalid) + int'(bus2.wack) + int'(bus2.error);
            if (np > 0) begin
                kind = bus2.rvalid ? K_RD : (bus2.wack ? K_WR : K_ERR);
                act = {kind, (kind == K_RD) ? bus2.rdata : 32'h0};
                n_cmp++;
                if (np > 1) begin
                    n_bad++;
                    $display("FAIL w2_pulse_count: got %0d pulses, required 1", np);
                end else if (exp_q2.size() == 0) begin
                    n_bad++;
                    $display("FAIL w2_unexpected: got %h, required no response", act);
                end else begin
                    e = exp_q2.pop_front();
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL w2_response: got %h, required %h", act, e);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [1:0]  kind;
        logic [33:0] act;
        logic [33:0] e;
        int          np;
        if (resetN) begin
            np = int'(bus0.rvalid) + int'(bus0.wack) + int'(bus0.error);
            if (np > 0) begin
                kind = bus0.rvalid ? K_RD : (bus0.wack ? K_WR : K_ERR);
                act = {kind, (kind == K_RD) ? bus0.rdata : 32'h0};
                n_cmp++;
                if (np > 1) begin
                    n_bad++;
                    $display("FAIL w0_pulse_count: got %0d pulses, required 1", np);
                end else if (exp_q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL w0_unexpected: got %h, required no response", act);
                end else begin
                    e = exp_q0.pop_front();
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL w0_response: got %h, required %h", act, e);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int held;
        int n_acc;
        int waited;
        model_clear();
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clock);

        // Reset state, observed while reset is still asserted.
        check("rst_ready2", bus2.ready, 1'b1);
        check("rst_ready0", bus0.ready, 1'b1);
        check("rst_pulses2", {bus2.rvalid, bus2.wack, bus2.error}, 3'b000);
        check("rst_rdata2", bus2.rdata, 32'h0);
        check("rst_state2", st2, IDLE);
        resetN = 1'b1;
        @(negedge clock);

        // Reset in the middle of a write to addr 3: aborted, no wack, memory untouched.
        issue(1'b0, 1'b1, 4'd3, 32'h1234_5678);
        void'(exp_q2.pop_back());
        void'(exp_q0.pop_back());
        model_clear();
        check("midbusy_state2", st2, BUSY);
        #2 resetN = 1'b0;
        @(negedge clock);
        check("abort_ready2", bus2.ready, 1'b1);
        check("abort_ready0", bus0.ready, 1'b1);
        check("abort_pulses2", {bus2.rvalid, bus2.wack, bus2.error}, 3'b000);
        check("abort_pulses0", {bus0.rvalid, bus0.wack, bus0.error}, 3'b000);
        check("abort_state0", st0, IDLE);
        #2 resetN = 1'b1;
        @(negedge clock);
        issue(1'b1, 1'b0, 4'd3, '0);

        // Read of a never-written address returns 0 and rdata holds afterwards.
        issue(1'b1, 1'b0, 4'd9, '0);
        wait_idle();
        @(negedge clock);
        check("rd9_hold2", bus2.rdata, 32'h0);
        check("rd9_hold0", bus0.rdata, 32'h0);

        // Write DEAD_BEEF to addr 5 with cycle-accurate ready/wack timing.
        issue(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            check($sformatf("w2_ready_edge%0d", k), bus2.ready, (k == 4));
            check($sformatf("w2_wack_edge%0d", k), bus2.wack, (k == 3));
            check($sformatf("w0_ready_edge%0d", k), bus0.ready, (k >= 2));
            check($sformatf("w0_wack_edge%0d", k), bus0.wack, (k == 1));
        end
        issue(1'b1, 1'b0, 4'd5, '0);
        wait_idle();
        @(negedge clock);
        check("rd5_rdata2", bus2.rdata, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 4'd7, 32'h0BAD_F00D);
        wait_idle();
        @(negedge clock);
        check("rdata_hold_after_write2", bus2.rdata, 32'hDEAD_BEEF);
        check("rdata_hold_after_write0", bus0.rdata, 32'hDEAD_BEEF);

        // read and write together in IDLE: error pulse, ready stays high, memory intact.
        issue(1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF);
        check("err_pulse2", bus2.error, 1'b1);
        check("err_ready2", bus2.ready, 1'b1);
        check("err_pulse0", bus0.error, 1'b1);
        issue(1'b1, 1'b0, 4'd5, '0);

        // Read strobe held high: re-accepted every WAIT_CYCLES+3 cycles.
        wait_idle();
        held = 12;
        drive(1'b1, 1'b0, 4'd5, '0);
        n_acc = (held + 2) / 3;
        for (int i = 0; i < n_acc; i++) exp_q0.push_back({K_RD, model_mem[5]});
        n_acc = (held + 4) / 5;
        for (int i = 0; i < n_acc; i++) exp_q2.push_back({K_RD, model_mem[5]});
        repeat (held) @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);

        // Back-to-back writes with strobe noise while both instances are busy.
        issue(1'b0, 1'b1, 4'd15, 32'hA5A5_0F0F);
        repeat (2) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            @(negedge clock);
        end
        drive(1'b0, 1'b0, '0, '0);
        issue(1'b0, 1'b1, 4'd0, 32'h5A5A_F0F0);
        issue(1'b1, 1'b0, 4'd15, '0);
        issue(1'b1, 1'b0, 4'd0, '0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) issue(1'b1, 1'b1, AW'($urandom_range(0, 15)), $urandom);
            else if (r <= 4) issue(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
            else if (r <= 8) issue(1'b0, 1'b1, AW'($urandom_range(0, 15)), $urandom);
            else repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        // Drain outstanding responses.
        waited = 0;
        while ((exp_q2.size() != 0 || exp_q0.size() != 0) && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("drain_q2", exp_q2.size(), 0);
        check("drain_q0", exp_q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
